usb_packet_decoder: RTL

- Receive-side packet decoder of the SIE; directly downstream of the transceiver's byte-level RX interface (rx_data/rx_active/rx_valid/rx_error).
- Checks PID integrity, splits token fields, checks CRC5/CRC16 and strips the CRC16 bytes from data payloads.
- Gives per-packet status strobes to the protocol engine. Runs on the same clock as the transceiver; no backpressure.

---
 rtl/usb_packet_decoder_pkg.sv | 81 ++++++++
 rtl/usb_crc16.sv | 28 ++
 rtl/usb_packet_decoder.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_packet_decoder_pkg.sv
// Shared types, constants and CRC helpers for the USB receive-side packet decoder.
package usb_packet_decoder_pkg;

  localparam int unsigned PID_W   = 4;
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned ENDP_W  = 4;
  localparam int unsigned FRAME_W = 11;

  typedef enum logic [PID_W-1:0] {
    PID_RSVD  = 4'h0,
    PID_OUT   = 4'h1,
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_PING  = 4'h4,
    PID_SOF   = 4'h5,
    PID_NYET  = 4'h6,
    PID_DATA2 = 4'h7,
    PID_SPLIT = 4'h8,
    PID_IN    = 4'h9,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_PRE   = 4'hC,
    PID_SETUP = 4'hD,
    PID_STALL = 4'hE,
    PID_MDATA = 4'hF
  } pid_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_TOK1,
    S_TOK2,
    S_DATA,
    S_WAIT_END
  } state_t;

  // What the packet-end evaluation has to report; KIND_DONE means already reported.
  typedef enum logic [2:0] {
    KIND_NONE,
    KIND_TOKEN,
    KIND_HS,
    KIND_DATA,
    KIND_DONE
  } kind_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ENDP_W-1:0] endp;
  } token_t;

  localparam logic [4:0]  CRC5_INIT      = 5'b11111;
  localparam logic [4:0]  CRC5_POLY      = 5'b00101;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // Serial CRC5 over one byte, bits taken in wire order (LSB first).
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[4] ^ data[i]) c = {c[3:0], 1'b0} ^ CRC5_POLY;
      else                c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  // Byte-parallel CRC16 update, bits taken in wire order (LSB first).
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide CRC16 accumulator for DATA payloads; clear has priority over enable.
module usb_crc16
  import usb_packet_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear)   crc_d = CRC16_INIT;
    else if (en) crc_d = crc16_byte(crc_q, data);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) crc_q <= CRC16_INIT;
    else          crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_packet_decoder.sv
// USB receive packet decoder: PID check, token/SOF split with CRC5, DATA CRC16 with CRC strip.
// Optional payload length limit enabled by defining USB_DECODER_MAXLEN_EN.
module usb_packet_decoder
  import usb_packet_decoder_pkg::*;
`ifdef USB_DECODER_MAXLEN_EN
#(
  parameter int unsigned MAX_PACKET = 64
)
`endif
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               usb_reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_active,
  input  logic               rx_valid,
  input  logic               rx_error,
  output logic [PID_W-1:0]   pid,
  output logic               token_valid,
  output logic [ADDR_W-1:0]  token_addr,
  output logic [ENDP_W-1:0]  token_endp,
  output logic               sof_valid,
  output logic [FRAME_W-1:0] sof_frame,
  output logic               hs_valid,
  output logic [7:0]         data_byte,
  output logic               data_valid,
  output logic               data_done,
  output logic               data_ok,
  output logic               pkt_error
);

  state_t             state_q, state_d;
  kind_t              kind_q, kind_d;
  logic               err_q, err_d;
  logic               end_q, end_d;
  logic               act_q, act_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         crc5_q, crc5_d;
  logic [7:0]         tok_lo_q, tok_lo_d;
  logic [2:0]         tok_hi_q, tok_hi_d;
  logic [7:0]         hold0_q, hold0_d;
  logic [7:0]         hold1_q, hold1_d;
  pid_t               pid_q, pid_d;
  token_t             token_q, token_d;
  logic [FRAME_W-1:0] sof_frame_q, sof_frame_d;
  logic               token_valid_q, token_valid_d;
  logic               sof_valid_q, sof_valid_d;
  logic               hs_valid_q, hs_valid_d;
  logic [7:0]         data_byte_q, data_byte_d;
  logic               data_valid_q, data_valid_d;
  logic               data_done_q, data_done_d;
  logic               data_ok_q, data_ok_d;
  logic               pkt_error_q, pkt_error_d;

  logic               crc_clr_c, crc_en_c;
  logic [15:0]        crc16_c;
  logic               rx_rise_c, rx_fall_c, pid_ok_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               tok_good_c, fwd_ok_c, data_good_c;

  usb_crc16 u_crc16 (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (crc_clr_c),
    .en      (crc_en_c),
    .data    (rx_data),
    .crc     (crc16_c)
  );

  assign rx_rise_c  = rx_active & ~act_q;
  assign rx_fall_c  = ~rx_active & act_q;
  assign pid_ok_c   = (rx_data[7:4] == ~rx_data[3:0]);
  assign cnt_inc_c  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign tok_good_c = !err_q && (cnt_q == CNT_W'(2)) && (crc5_q == CRC5_RESIDUAL);

  // The holding pipe is full once two payload bytes are in; the oldest leaves on each new byte.
`ifdef USB_DECODER_MAXLEN_EN
  assign fwd_ok_c    = (cnt_q >= CNT_W'(2)) && (32'(cnt_q) < MAX_PACKET + 32'd2);
  assign data_good_c = !err_q && (cnt_q >= CNT_W'(2)) && (crc16_c == CRC16_RESIDUAL) &&
                       (32'(cnt_q) <= MAX_PACKET + 32'd2);
`else
  assign fwd_ok_c    = (cnt_q >= CNT_W'(2));
  assign data_good_c = !err_q && (cnt_q >= CNT_W'(2)) && (crc16_c == CRC16_RESIDUAL);
`endif

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    err_d         = err_q;
    end_d         = 1'b0;
    act_d         = rx_active;
    cnt_d         = cnt_q;
    crc5_d        = crc5_q;
    tok_lo_d      = tok_lo_q;
    tok_hi_d      = tok_hi_q;
    hold0_d       = hold0_q;
    hold1_d       = hold1_q;
    pid_d         = pid_q;
    token_d       = token_q;
    sof_frame_d   = sof_frame_q;
    token_valid_d = 1'b0;
    sof_valid_d   = 1'b0;
    hs_valid_d    = 1'b0;
    data_byte_d   = data_byte_q;
    data_valid_d  = 1'b0;
    data_done_d   = 1'b0;
    data_ok_d     = 1'b0;
    pkt_error_d   = 1'b0;
    crc_clr_c     = 1'b0;
    crc_en_c      = 1'b0;

    if (end_q) begin
      // Packet-end report, one cycle after rx_active fell (any byte in that cycle already taken)
      state_d = S_IDLE;
      err_d   = 1'b0;
      case (kind_q)
        KIND_TOKEN: begin
          if (tok_good_c) begin
            if (pid_q == PID_SOF) begin
              sof_valid_d = 1'b1;
              sof_frame_d = {tok_hi_q, tok_lo_q};
            end else begin
              token_valid_d = 1'b1;
              token_d.addr  = tok_lo_q[6:0];
              token_d.endp  = {tok_hi_q, tok_lo_q[7]};
            end
          end else begin
            pkt_error_d = 1'b1;
          end
        end
        KIND_HS: begin
          if (!err_q && cnt_q == '0) hs_valid_d  = 1'b1;
          else                       pkt_error_d = 1'b1;
        end
        KIND_DATA: begin
          data_done_d = 1'b1;
          data_ok_d   = data_good_c;
          pkt_error_d = !data_good_c;
        end
        KIND_DONE: pkt_error_d = err_q;
        default:   pkt_error_d = 1'b1;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_rise_c) begin
            state_d = S_PID;
            kind_d  = KIND_NONE;
            err_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        S_PID: begin
          if (rx_error) begin
            err_d   = 1'b1;
            state_d = S_WAIT_END;
          end else if (rx_valid) begin
            if (!pid_ok_c) begin
              pkt_error_d = 1'b1;
              kind_d      = KIND_DONE;
              state_d     = S_WAIT_END;
            end else begin
              pid_d = pid_t'(rx_data[3:0]);
              case (rx_data[3:0])
                PID_OUT, PID_IN, PID_SETUP, PID_SOF: begin
                  kind_d  = KIND_TOKEN;
                  crc5_d  = CRC5_INIT;
                  state_d = S_TOK1;
                end
                PID_DATA0, PID_DATA1: begin
                  kind_d    = KIND_DATA;
                  crc_clr_c = 1'b1;
                  state_d   = S_DATA;
                end
                PID_ACK, PID_NAK, PID_STALL: begin
                  kind_d  = KIND_HS;
                  state_d = S_WAIT_END;
                end
                default: begin
                  pkt_error_d = 1'b1;
                  kind_d      = KIND_DONE;
                  state_d     = S_WAIT_END;
                end
              endcase
            end
          end
        end
        S_TOK1, S_TOK2, S_DATA, S_WAIT_END: begin
          if (rx_error) begin
            err_d   = 1'b1;
            state_d = S_WAIT_END;
          end else if (rx_valid) begin
            cnt_d = cnt_inc_c;
            case (state_q)
              S_TOK1: begin
                crc5_d   = crc5_byte(crc5_q, rx_data);
                tok_lo_d = rx_data;
                state_d  = S_TOK2;
              end
              S_TOK2: begin
                crc5_d   = crc5_byte(crc5_q, rx_data);
                tok_hi_d = rx_data[2:0];
                state_d  = S_WAIT_END;
              end
              S_DATA: begin
                crc_en_c = 1'b1;
                hold1_d  = hold0_q;
                hold0_d  = rx_data;
                if (fwd_ok_c) begin
                  data_byte_d  = hold1_q;
                  data_valid_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        default: state_d = S_IDLE;
      endcase
      end_d = (state_q != S_IDLE) && rx_fall_c;
    end

    // Bus reset clears everything, exactly like reset_n but synchronously
    if (usb_reset) begin
      state_d       = S_IDLE;
      kind_d        = KIND_NONE;
      err_d         = 1'b0;
      end_d         = 1'b0;
      act_d         = 1'b0;
      cnt_d         = '0;
      crc5_d        = CRC5_INIT;
      tok_lo_d      = '0;
      tok_hi_d      = '0;
      hold0_d       = '0;
      hold1_d       = '0;
      pid_d         = PID_RSVD;
      token_d       = '0;
      sof_frame_d   = '0;
      token_valid_d = 1'b0;
      sof_valid_d   = 1'b0;
      hs_valid_d    = 1'b0;
      data_byte_d   = '0;
      data_valid_d  = 1'b0;
      data_done_d   = 1'b0;
      data_ok_d     = 1'b0;
      pkt_error_d   = 1'b0;
      crc_clr_c     = 1'b1;
      crc_en_c      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      kind_q        <= KIND_NONE;
      err_q         <= 1'b0;
      end_q         <= 1'b0;
      act_q         <= 1'b0;
      cnt_q         <= '0;
      crc5_q        <= CRC5_INIT;
      tok_lo_q      <= '0;
      tok_hi_q      <= '0;
      hold0_q       <= '0;
      hold1_q       <= '0;
      pid_q         <= PID_RSVD;
      token_q       <= '0;
      sof_frame_q   <= '0;
      token_valid_q <= 1'b0;
      sof_valid_q   <= 1'b0;
      hs_valid_q    <= 1'b0;
      data_byte_q   <= '0;
      data_valid_q  <= 1'b0;
      data_done_q   <= 1'b0;
      data_ok_q     <= 1'b0;
      pkt_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      err_q         <= err_d;
      end_q         <= end_d;
      act_q         <= act_d;
      cnt_q         <= cnt_d;
      crc5_q        <= crc5_d;
      tok_lo_q      <= tok_lo_d;
      tok_hi_q      <= tok_hi_d;
      hold0_q       <= hold0_d;
      hold1_q       <= hold1_d;
      pid_q         <= pid_d;
      token_q       <= token_d;
      sof_frame_q   <= sof_frame_d;
      token_valid_q <= token_valid_d;
      sof_valid_q   <= sof_valid_d;
      hs_valid_q    <= hs_valid_d;
      data_byte_q   <= data_byte_d;
      data_valid_q  <= data_valid_d;
      data_done_q   <= data_done_d;
      data_ok_q     <= data_ok_d;
      pkt_error_q   <= pkt_error_d;
    end
  end

  assign pid         = pid_q;
  assign token_valid = token_valid_q;
  assign token_addr  = token_q.addr;
  assign token_endp  = token_q.endp;
  assign sof_valid   = sof_valid_q;
  assign sof_frame   = sof_frame_q;
  assign hs_valid    = hs_valid_q;
  assign data_byte   = data_byte_q;
  assign data_valid  = data_valid_q;
  assign data_done   = data_done_q;
  assign data_ok     = data_ok_q;
  assign pkt_error   = pkt_error_q;

endmodule
